// File: rtl/complex_acc_dump.sv
// Integrate-and-dump stage for signed complex products: sums up to ACC_LEN samples per frame,
// then rounds, shifts and saturates the frame sum into a one-entry valid/ready output register.
module complex_acc_dump #(
    parameter int  IN_W    = 19,
    parameter int  ACC_LEN = 8,
    parameter int  SHIFT   = 3,
    parameter int  OUT_W   = 16,
    localparam int CNT_W   = $clog2(ACC_LEN + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [IN_W-1:0]  in_re,
    input  logic signed [IN_W-1:0]  in_im,
    input  logic                    in_valid,
    input  logic                    in_last,
    output logic                    in_ready,
    output logic signed [OUT_W-1:0] out_re,
    output logic signed [OUT_W-1:0] out_im,
    output logic [CNT_W-1:0]        out_cnt,
    output logic                    out_sat,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int LOG_LEN = $clog2(ACC_LEN);
    localparam int ACC_W   = (LOG_LEN > 0) ? (IN_W + LOG_LEN) : (IN_W + 1);
    localparam int EXT_W   = ACC_W - IN_W;

    localparam logic [ACC_W:0]        ONE      = {{ACC_W{1'b0}}, 1'b1};
    localparam logic [ACC_W:0]        HALF     = (SHIFT > 0) ? (ONE << ((SHIFT > 0) ? (SHIFT - 1) : 0)) : '0;
    localparam logic signed [ACC_W:0] SAT_MAX  = {{(ACC_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN  = ~SAT_MAX;
    localparam logic [CNT_W-1:0]      LAST_CNT = CNT_W'(ACC_LEN - 1);

    typedef enum logic [0:0] {
        ST_ACC  = 1'b0,
        ST_FULL = 1'b1
    } state_t;

    state_t                   state_r;
    state_t                   state_next_s;
    logic signed [ACC_W-1:0]  acc_re_r;
    logic signed [ACC_W-1:0]  acc_im_r;
    logic [CNT_W-1:0]         count_r;
    logic signed [ACC_W-1:0]  sum_re_s;
    logic signed [ACC_W-1:0]  sum_im_s;
    logic [OUT_W:0]           rs_re_s;
    logic [OUT_W:0]           rs_im_s;
    logic                     xfer_in_s;
    logic                     xfer_out_s;
    logic                     last_s;
    logic                     dump_s;

    // Round half-up, arithmetic shift, clamp; MSB of the result flags a clip.
    function automatic logic [OUT_W:0] round_sat(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W:0] r;
        logic signed [ACC_W:0] s;
        r = {v[ACC_W-1], v} + HALF;
        s = r >>> SHIFT;
        if (s > SAT_MAX) begin
            round_sat = {1'b1, SAT_MAX[OUT_W-1:0]};
        end else if (s < SAT_MIN) begin
            round_sat = {1'b1, SAT_MIN[OUT_W-1:0]};
        end else begin
            round_sat = {1'b0, s[OUT_W-1:0]};
        end
    endfunction

    // Handshakes, frame-close detection and the running sums.
    always_comb begin
        in_ready   = (state_r == ST_ACC) || out_ready;
        xfer_in_s  = in_valid && in_ready;
        xfer_out_s = out_valid && out_ready;
        last_s     = (count_r == LAST_CNT) || in_last;
        dump_s     = xfer_in_s && last_s;
        sum_re_s   = acc_re_r + {{EXT_W{in_re[IN_W-1]}}, in_re};
        sum_im_s   = acc_im_r + {{EXT_W{in_im[IN_W-1]}}, in_im};
        rs_re_s    = round_sat(sum_re_s);
        rs_im_s    = round_sat(sum_im_s);
    end

    // Next state: a dump fills the output; a drain without a refill empties it.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_ACC: begin
                if (dump_s) begin
                    state_next_s = ST_FULL;
                end else begin
                    state_next_s = ST_ACC;
                end
            end
            ST_FULL: begin
                if (xfer_out_s && !dump_s) begin
                    state_next_s = ST_ACC;
                end else begin
                    state_next_s = ST_FULL;
                end
            end
            default: state_next_s = ST_ACC;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_ACC;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Accumulator and sample counter; cleared when a frame is dumped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_re_r <= '0;
            acc_im_r <= '0;
            count_r  <= '0;
        end else if (xfer_in_s) begin
            if (last_s) begin
                acc_re_r <= '0;
                acc_im_r <= '0;
                count_r  <= '0;
            end else begin
                acc_re_r <= sum_re_s;
                acc_im_r <= sum_im_s;
                count_r  <= count_r + {{(CNT_W - 1){1'b0}}, 1'b1};
            end
        end
    end

    // Output register: loaded only on a dump, valid cleared on a drain without refill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_re    <= '0;
            out_im    <= '0;
            out_cnt   <= '0;
            out_sat   <= 1'b0;
            out_valid <= 1'b0;
        end else if (dump_s) begin
            out_re    <= rs_re_s[OUT_W-1:0];
            out_im    <= rs_im_s[OUT_W-1:0];
            out_cnt   <= count_r + {{(CNT_W - 1){1'b0}}, 1'b1};
            out_sat   <= rs_re_s[OUT_W] | rs_im_s[OUT_W];
            out_valid <= 1'b1;
        end else if (xfer_out_s) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_complex_acc_dump.sv
// Directed bench for complex_acc_dump: default instance for frame behaviour,
// a second ACC_LEN=1 instance for back-to-back streaming.
module tb_complex_acc_dump;

    logic               clk;
    logic               rst_n;
    logic signed [18:0] in_re, in_im;
    logic               in_valid, in_last, in_ready;
    logic signed [15:0] out_re, out_im;
    logic [3:0]         out_cnt;
    logic               out_sat, out_valid, out_ready;

    logic signed [18:0] b_in_re, b_in_im;
    logic               b_in_valid, b_in_last, b_in_ready;
    logic signed [15:0] b_out_re, b_out_im;
    logic [0:0]         b_out_cnt;
    logic               b_out_sat, b_out_valid, b_out_ready;

    int total = 0;
    int bad   = 0;

    complex_acc_dump u_dut (
        .clk(clk), .rst_n(rst_n), .in_re(in_re), .in_im(in_im),
        .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .out_re(out_re), .out_im(out_im), .out_cnt(out_cnt), .out_sat(out_sat),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    complex_acc_dump #(.ACC_LEN(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_re(b_in_re), .in_im(b_in_im),
        .in_valid(b_in_valid), .in_last(b_in_last), .in_ready(b_in_ready),
        .out_re(b_out_re), .out_im(b_out_im), .out_cnt(b_out_cnt), .out_sat(b_out_sat),
        .out_valid(b_out_valid), .out_ready(b_out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_n(input int n, input logic signed [18:0] re, input logic signed [18:0] im,
                          input logic last);
        for (int i = 0; i < n; i++) begin
            in_re    = re;
            in_im    = im;
            in_last  = last;
            in_valid = 1'b1;
            tick();
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
        tick();
    endtask

    logic signed [18:0] b_vals [6];
    logic signed [15:0] b_exp  [6];

    initial begin
        rst_n = 1'b0;
        in_re = '0; in_im = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        b_in_re = '0; b_in_im = '0; b_in_valid = 1'b0; b_in_last = 1'b0; b_out_ready = 1'b1;
        b_vals = '{19'sd0, 19'sd4, 19'sd8, 19'sd12, -19'sd4, -19'sd12};
        b_exp  = '{16'sd0, 16'sd1, 16'sd1, 16'sd2,  16'sd0,  -16'sd1};
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_re", out_re, 0);
        chk("rst_out_cnt", out_cnt, 0);
        chk("rst_out_sat", out_sat, 0);
        chk("rst_in_ready", in_ready, 1);

        // Full 8-sample frame of +100/-100
        send_n(7, 19'sd100, -19'sd100, 1'b0);
        chk("t2_valid_before_8th", out_valid, 0);
        send_n(1, 19'sd100, -19'sd100, 1'b0);
        chk("t2_valid", out_valid, 1);
        chk("t2_re", out_re, 100);
        chk("t2_im", out_im, -100);
        chk("t2_cnt", out_cnt, 8);
        chk("t2_sat", out_sat, 0);
        idle();
        chk("t2_drained", out_valid, 0);
        chk("t2_held_re", out_re, 100);

        // Async reset mid-frame discards partial sum
        send_n(3, 19'sd50, 19'sd50, 1'b0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t1_rst_re", out_re, 0);
        chk("t1_rst_im", out_im, 0);
        chk("t1_rst_cnt", out_cnt, 0);
        tick();
        rst_n = 1'b1;
        tick();
        send_n(8, 19'sd10, 19'sd20, 1'b0);
        chk("t1_post_valid", out_valid, 1);
        chk("t1_post_re", out_re, 10);
        chk("t1_post_im", out_im, 20);
        chk("t1_post_cnt", out_cnt, 8);
        idle();

        // Rounding, then a one-product frame closed by in_last straight after a dump
        send_n(8, 19'sd1, 19'sd0, 1'b0);
        chk("t3_re_a", out_re, 1);
        chk("t3_cnt_a", out_cnt, 8);
        send_n(1, -19'sd5, 19'sd0, 1'b1);
        chk("t3_valid_b", out_valid, 1);
        chk("t3_re_b", out_re, -1);
        chk("t3_im_b", out_im, 0);
        chk("t3_cnt_b", out_cnt, 1);
        idle();

        // Saturation both directions
        send_n(8, 19'sd262143, -19'sd262144, 1'b0);
        chk("t4_re", out_re, 32767);
        chk("t4_im", out_im, -32768);
        chk("t4_sat", out_sat, 1);
        idle();

        // Backpressure: output held, input stalled, nothing lost on release
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            send_n(1, 19'(i), 19'sd0, 1'b0);
        end
        chk("t5_valid", out_valid, 1);
        chk("t5_re", out_re, 5);
        chk("t5_sat", out_sat, 0);
        in_re = 19'sd16; in_im = 19'sd0; in_valid = 1'b1;
        #1;
        chk("t5_in_ready_low", in_ready, 0);
        tick();
        tick();
        tick();
        chk("t5_stall_re", out_re, 5);
        chk("t5_stall_cnt", out_cnt, 8);
        chk("t5_stall_valid", out_valid, 1);
        out_ready = 1'b1;
        #1;
        chk("t5_in_ready_high", in_ready, 1);
        send_n(1, 19'sd16, 19'sd0, 1'b0);
        chk("t5_drain", out_valid, 0);
        send_n(6, 19'sd16, 19'sd0, 1'b0);
        chk("t5_no_early_dump", out_valid, 0);
        send_n(1, 19'sd16, 19'sd0, 1'b0);
        chk("t5_valid2", out_valid, 1);
        chk("t5_re2", out_re, 16);
        chk("t5_cnt2", out_cnt, 8);
        idle();

        // Back-to-back on ACC_LEN=1: a new dump every cycle with no bubble
        for (int i = 0; i < 6; i++) begin
            b_in_re    = b_vals[i];
            b_in_im    = -b_vals[i];
            b_in_valid = 1'b1;
            #1;
            chk("t6_in_ready", b_in_ready, 1);
            tick();
            chk("t6_valid", b_out_valid, 1);
            chk("t6_re", b_out_re, b_exp[i]);
            chk("t6_cnt", b_out_cnt, 1);
        end
        b_in_valid = 1'b0;
        tick();
        chk("t6_drained", b_out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
